// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU power controller: FSM state encoding and
// the encoding used to report which event woke the core.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_SLEEP = 2'b10,
    ST_WAKE  = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_PIN   = 2'b01;
  localparam logic [1:0] CAUSE_TIMER = 2'b10;
  localparam logic [1:0] CAUSE_BOTH  = 2'b11;

  function automatic logic [1:0] wake_cause_f(input logic pin_hit, input logic timer_hit);
    if (pin_hit && timer_hit) return CAUSE_BOTH;
    if (timer_hit)            return CAUSE_TIMER;
    if (pin_hit)              return CAUSE_PIN;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/cpu_power_ctrl_wake_sync.sv
// Wake pin conditioning: 2-flop synchronizer, saturating debounce counter and a
// rising-edge detector on the debounced level.
module wake_sync
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_async,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // cnt_q holds how many earlier cycles sync2_q was already high, so the
  // current high cycle completes the DEBOUNCE-long run without extra latency.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q < CW'(DEBOUNCE)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level = sync2_q && (cnt_q >= CW'(DEBOUNCE - 1));
  assign rise  = level && !level_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= pin_async;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_prev_q <= level;
    end
  end

endmodule

// File: rtl/cpu_power_ctrl.sv
// Sleep/wake sequencer for the 4-bit accumulator CPU: drains the core, gates its
// clock enable, and wakes it on a debounced pin edge or sleep-timer expiry.
module cpu_power_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMER_W    = 8,
  parameter int DEBOUNCE   = 2,
  parameter int WAKE_DELAY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sleep_req,
  input  logic               cpu_idle,
  input  logic               wakeup,
  input  logic [TIMER_W-1:0] timer_load,
  output logic               cpu_en,
  output logic               sleeping,
  output logic [1:0]         wake_cause,
  output logic               wake_valid,
  output logic [1:0]         state_o
);

  localparam int DW = (WAKE_DELAY < 1) ? 1 : $clog2(WAKE_DELAY + 1);

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [DW-1:0]      delay_q;
  logic               cpu_en_q;
  logic               sleeping_q;
  logic               wake_valid_q;
  logic [1:0]         cause_q;
  logic               pin_level;
  logic               pin_rise;
  logic               pin_hit;
  logic               timer_hit;

  wake_sync #(
    .DEBOUNCE(DEBOUNCE)
  ) u_wake_sync (
    .clk      (clk),
    .reset    (reset),
    .pin_async(wakeup),
    .level    (pin_level),
    .rise     (pin_rise)
  );

  assign pin_hit   = pin_level && pin_rise;
  assign timer_hit = (timer_q == TIMER_W'(1));

  // A zero timer never reaches the count of one, so timer_load=0 disables it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      timer_q      <= '0;
      delay_q      <= '0;
      cpu_en_q     <= 1'b1;
      sleeping_q   <= 1'b0;
      wake_valid_q <= 1'b0;
      cause_q      <= CAUSE_NONE;
    end else begin
      wake_valid_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (sleep_req) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cpu_idle) begin
            state_q    <= ST_SLEEP;
            cpu_en_q   <= 1'b0;
            sleeping_q <= 1'b1;
            timer_q    <= timer_load;
            cause_q    <= CAUSE_NONE;
          end
        end
        ST_SLEEP: begin
          if (timer_q != '0) timer_q <= timer_q - 1'b1;
          if (timer_hit || pin_hit) begin
            state_q    <= ST_WAKE;
            sleeping_q <= 1'b0;
            cause_q    <= wake_cause_f(pin_hit, timer_hit);
            delay_q    <= DW'(WAKE_DELAY - 1);
            timer_q    <= '0;
          end
        end
        ST_WAKE: begin
          if (delay_q == '0) begin
            state_q      <= ST_RUN;
            cpu_en_q     <= 1'b1;
            wake_valid_q <= 1'b1;
          end else begin
            delay_q <= delay_q - 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign cpu_en     = cpu_en_q;
  assign sleeping   = sleeping_q;
  assign wake_cause = cause_q;
  assign wake_valid = wake_valid_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cpu_power_ctrl.sv
// Scoreboard bench for cpu_power_ctrl: a timestamp-based reference model predicts
// each wake event and every cycle's outputs; a negedge monitor checks the DUT.
module tb_cpu_power_ctrl;

  localparam int D  = 2;
  localparam int WD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sleepReq = 1'b0;
  logic       cpuIdle = 1'b0;
  logic       wakeup = 1'b0;
  logic [7:0] timerLoad = 8'd0;
  logic       cpuEn;
  logic       sleeping;
  logic [1:0] wakeCause;
  logic       wakeValid;
  logic [1:0] stateO;

  int checks = 0;
  int failures = 0;
  int lastCause = -1;

  typedef struct packed {
    int         atEdge;
    logic [1:0] cause;
  } wakeEvt_t;
  wakeEvt_t sbq[$];
  wakeEvt_t popped;

  // Model state: mode 0=RUN 1=DRAIN 2=SLEEP 3=WAKE, deadlines in edge numbers
  int       edgeNo = 0;
  int       mMode = 0;
  int       sleepDeadline = -1;
  int       runEdge = 0;
  int       pinStreak = 0;
  bit       lvl1 = 1'b0;
  bit       lvl2 = 1'b0;
  bit       riseSeen, lvlNew, tHit, pHit;
  bit       mValid = 1'b0;
  logic [1:0] mCause = 2'd0;

  cpu_power_ctrl #(
    .TIMER_W   (8),
    .DEBOUNCE  (D),
    .WAKE_DELAY(WD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sleep_req (sleepReq),
    .cpu_idle  (cpuIdle),
    .wakeup    (wakeup),
    .timer_load(timerLoad),
    .cpu_en    (cpuEn),
    .sleeping  (sleeping),
    .wake_cause(wakeCause),
    .wake_valid(wakeValid),
    .state_o   (stateO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at edge %0d", name, actual, expected, edgeNo);
    end
  endtask

  task automatic applyStimulus(input bit sr, input bit idle, input bit wk,
                               input logic [7:0] tl, input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      sleepReq  = sr;
      cpuIdle   = idle;
      wakeup    = wk;
      timerLoad = tl;
    end
  endtask

  // Reference model: the pin counts as high after D consecutive high samples
  // (plus one synchronizer edge); wake deadlines are absolute edge numbers.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mMode = 0; mCause = 2'd0; mValid = 1'b0;
      pinStreak = 0; lvl1 = 1'b0; lvl2 = 1'b0;
      sleepDeadline = -1;
      sbq.delete();
    end else begin
      edgeNo++;
      riseSeen  = lvl1 && !lvl2;
      lvlNew    = (pinStreak >= D);
      pinStreak = wakeup ? ((pinStreak < 1000) ? pinStreak + 1 : pinStreak) : 0;
      lvl2 = lvl1;
      lvl1 = lvlNew;
      mValid = 1'b0;
      case (mMode)
        0: if (sleepReq) mMode = 1;
        1: if (cpuIdle) begin
             mMode = 2;
             mCause = 2'd0;
             sleepDeadline = (timerLoad == 8'd0) ? -1 : edgeNo + int'(timerLoad);
           end
        2: begin
             tHit = (edgeNo == sleepDeadline);
             pHit = riseSeen;
             if (tHit || pHit) begin
               mMode = 3;
               mCause = 2'((pHit ? 1 : 0) + (tHit ? 2 : 0));
               runEdge = edgeNo + WD;
               sbq.push_back('{atEdge: runEdge, cause: mCause});
             end
           end
        default: if (edgeNo == runEdge) begin
             mMode = 0;
             mValid = 1'b1;
           end
      endcase
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on each wake pulse
  always @(negedge clk) begin
    checkOutput("state", int'(stateO), mMode);
    checkOutput("cpu_en", int'(cpuEn), (mMode < 2) ? 1 : 0);
    checkOutput("sleeping", int'(sleeping), (mMode == 2) ? 1 : 0);
    checkOutput("wake_cause", int'(wakeCause), int'(mCause));
    checkOutput("wake_valid", int'(wakeValid), int'(mValid));
    if (wakeValid === 1'b1) begin
      if (sbq.size() == 0) begin
        checkOutput("wake_unexpected_queue_len", 0, 1);
      end else begin
        popped = sbq.pop_front();
        checkOutput("wake_edge", edgeNo, popped.atEdge);
        checkOutput("wake_cause_sb", int'(wakeCause), int'(popped.cause));
        lastCause = int'(wakeCause);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_state", int'(stateO), 0);
    checkOutput("reset_cpu_en", int'(cpuEn), 1);
    checkOutput("reset_sleeping", int'(sleeping), 0);
    checkOutput("reset_cause", int'(wakeCause), 0);
    checkOutput("reset_valid", int'(wakeValid), 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 3);

    // Timer wake after a 4-cycle drain
    lastCause = -1;
    applyStimulus(1, 0, 0, 8'd5, 1);
    applyStimulus(0, 0, 0, 8'd5, 3);
    applyStimulus(0, 1, 0, 8'd5, 1);
    applyStimulus(0, 0, 0, 8'd0, 16);
    checkOutput("timer_cause", lastCause, 2);

    // Pin wake, with a single-cycle glitch first
    lastCause = -1;
    applyStimulus(1, 1, 0, 8'd0, 1);
    applyStimulus(0, 1, 0, 8'd0, 10);
    applyStimulus(0, 1, 1, 8'd0, 1);
    applyStimulus(0, 1, 0, 8'd0, 6);
    checkOutput("glitch_no_wake", int'(stateO), 2);
    applyStimulus(0, 1, 1, 8'd0, 8);
    applyStimulus(0, 1, 0, 8'd0, 8);
    checkOutput("pin_cause", lastCause, 1);

    // Pin toggled in RUN, then held high across SLEEP entry
    lastCause = -1;
    applyStimulus(0, 0, 1, 8'd0, 3);
    applyStimulus(0, 0, 0, 8'd0, 2);
    applyStimulus(0, 0, 1, 8'd0, 4);
    checkOutput("run_ignores_pin", int'(stateO), 0);
    applyStimulus(1, 1, 1, 8'd0, 1);
    applyStimulus(0, 1, 1, 8'd0, 10);
    checkOutput("held_pin_sleep", int'(stateO), 2);
    applyStimulus(0, 1, 0, 8'd0, 3);
    applyStimulus(0, 1, 1, 8'd0, 8);
    applyStimulus(0, 1, 0, 8'd0, 8);
    checkOutput("rearm_cause", lastCause, 1);

    // Debounced pin rise lands on the timer expiry edge
    lastCause = -1;
    applyStimulus(1, 1, 0, 8'd3, 1);
    applyStimulus(0, 1, 1, 8'd3, 12);
    applyStimulus(0, 1, 0, 8'd0, 4);
    checkOutput("both_cause", lastCause, 3);

    // sleep_req pulses in DRAIN, SLEEP and WAKE
    lastCause = -1;
    applyStimulus(1, 0, 0, 8'd4, 1);
    applyStimulus(1, 0, 0, 8'd4, 1);
    applyStimulus(0, 1, 0, 8'd4, 1);
    applyStimulus(1, 0, 0, 8'd4, 1);
    applyStimulus(0, 0, 0, 8'd4, 3);
    applyStimulus(1, 0, 0, 8'd4, 1);
    applyStimulus(0, 0, 0, 8'd0, 8);
    checkOutput("ignore_req_cause", lastCause, 2);
    checkOutput("ignore_req_state", int'(stateO), 0);

    // Reset pulse mid-SLEEP
    applyStimulus(1, 1, 0, 8'd9, 1);
    applyStimulus(0, 1, 0, 8'd9, 4);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midsleep_reset_state", int'(stateO), 0);
    checkOutput("midsleep_reset_cpu_en", int'(cpuEn), 1);
    checkOutput("midsleep_reset_cause", int'(wakeCause), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    applyStimulus(0, 0, 0, 8'd0, 12);
    checkOutput("post_reset_run", int'(stateO), 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #2;
      reset     = ($urandom_range(0, 299) != 0);
      sleepReq  = ($urandom_range(0, 7) == 0);
      cpuIdle   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) wakeup = ~wakeup;
      timerLoad = 8'($urandom_range(0, 12));
    end
    @(posedge clk);
    #2 reset = 1'b1;

    // Flush: force any pending sleep to complete so the scoreboard empties
    applyStimulus(0, 1, 0, 8'd0, 5);
    applyStimulus(0, 1, 1, 8'd0, 10);
    applyStimulus(0, 1, 0, 8'd0, 10);
    checkOutput("scoreboard_empty", sbq.size(), 0);
    checkOutput("final_state", int'(stateO), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_power_ctrl.md
# cpu_power_ctrl

Sleep/wake sequencer for the 4-bit accumulator CPU. It sits between the CPU core and the board-level wake pin. It drains the core to an instruction boundary when a SLEEP instruction retires, then gates the core via a clock enable. It wakes the core on a debounced rising edge of `wakeup` or on expiry of a programmable sleep timer, and reports why the core woke.

## Interface
Parameters:
- `TIMER_W`, 8: width of sleep timer.
- `DEBOUNCE`, 2: consecutive synchronized-high cycles needed before `wakeup` counts as asserted (≥1).
- `WAKE_DELAY`, 4: cycles the core stays gated after a wake event, for settling (≥1).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `sleep_req`  in  1  one-cycle pulse from CPU decode when the SLEEP opcode executes.
- `cpu_idle`  in  1  CPU is at an instruction boundary (fetch state).
- `wakeup`  in  1  external wake pin, asynchronous to `clk`.
- `timer_load`  in  TIMER_W  sleep duration in cycles, sampled on SLEEP entry; 0 = timer disabled.
- `cpu_en`  out  1  clock enable to CPU core.
- `sleeping`  out  1  high in SLEEP state only.
- `wake_cause`  out  2  00 none, 01 pin, 10 timer, 11 both; holds until next SLEEP entry.
- `wake_valid`  out  1  one-cycle pulse on the first cycle back in RUN.
- `state_o`  out  2  current state encoding.

## Operation
- States: RUN=00, DRAIN=01, SLEEP=10, WAKE=11.
- RUN:
  - `cpu_en`=1.
  - `sleep_req`=1 → DRAIN.
- DRAIN:
  - `cpu_en`=1.
  - `cpu_idle`=1 sampled → SLEEP. `cpu_en` goes 0 from that edge.
  - On entry to SLEEP: timer latches `timer_load`, and `wake_cause` clears to 00.
  - If `cpu_idle` is already 1 on the cycle after `sleep_req`, DRAIN lasts exactly 1 cycle.
- SLEEP:
  - `cpu_en`=0, `sleeping`=1.
  - Nonzero timer decrements each cycle. SLEEP lasts exactly `timer_load` cycles when only the timer wakes the core.
  - Pin wake requires a rising edge of the debounced signal seen while in SLEEP. If the pin is already high on SLEEP entry, it must go low then high again.
  - Either event → WAKE, with `wake_cause` set accordingly. Both events on the same cycle → 11.
- WAKE:
  - `cpu_en`=0.
  - Counts `WAKE_DELAY` cycles, then → RUN.
  - `wake_valid` pulses on the first RUN cycle.
- Ignored inputs:
  - `sleep_req` outside RUN.
  - `wakeup` outside SLEEP. The debouncer still tracks the pin level, but no event is generated.
- Pin synchronizer: 2 flops.
- Debouncer:
  - A saturating counter resets to 0 whenever the synchronized pin is low.
  - The debounced level is high once the count reaches `DEBOUNCE`.
- Reset (async, any state):
  - State → RUN; `cpu_en`=1; `sleeping`=0; `wake_cause`=00; `wake_valid`=0; `state_o`=00.
  - Synchronizer, debounce counter, timer and delay counter → 0.

## Timing
- `sleep_req` at edge E → `state_o`=DRAIN after E.
- Idle seen at edge F → SLEEP and `cpu_en`=0 after F.
- Pin latency: pin stable high before edge N, while in SLEEP → WAKE after edge N+1+DEBOUNCE. With defaults, that is N+3.
- Timer latency: SLEEP entered at edge S with `timer_load`=T → WAKE after edge S+T.
- WAKE entered at edge W → RUN, `cpu_en`=1 and `wake_valid`=1 after edge W+WAKE_DELAY.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Shared package `cpu_pkg` holds:
  - state enum (RUN/DRAIN/SLEEP/WAKE);
  - `wake_cause` encodings (CAUSE_NONE/PIN/TIMER/BOTH).
- One sub-module, `wake_sync`: 2-flop synchronizer, debounce counter and rising-edge detector. Ports are `clk`, `reset`, `pin_async`, `level`, `rise`.
- The top level holds the FSM, sleep timer and wake-delay counter.

## Test plan
- Reset mid-SLEEP (`reset`=0 for 1 cycle) → RUN immediately, `cpu_en`=1, `wake_cause`=00, timer cleared.
- `sleep_req` with `cpu_idle`=0 for 3 cycles, then 1 → DRAIN for 4 cycles, then SLEEP. `timer_load`=5 → WAKE exactly 5 cycles later, `wake_cause`=10, RUN 4 cycles after that, `wake_valid` pulses once.
- `timer_load`=0, pin raised 10 cycles into SLEEP → WAKE 3 edges later, `wake_cause`=01. A 1-cycle pin glitch alone → no wake.
- Pin held high across SLEEP entry, `timer_load`=0 → stays in SLEEP. Pin low 3 cycles, then high → wake, cause 01.
- Pin edge timed so the debounced rise coincides with timer expiry (`timer_load`=3) → `wake_cause`=11.
- `sleep_req` pulsed during DRAIN, SLEEP and WAKE → ignored. `wakeup` toggled in RUN → no state change.
